// File: rtl/audio_event_sequencer.sv
// Prioritised, preemptible sound-event player timed by a slow tick pulse.
// Optional feature: define AUDIO_PENDING_EN to remember dropped requests and replay them from idle.
module audio_event_sequencer #(
    parameter int NUM_EVENTS = 4,
    parameter int DUR_W      = 4,
    parameter int GAP_TICKS  = 1,
    parameter int IDLE_KEY   = 15
) (
    input  logic                            clk,
    input  logic                            resetN,
    input  logic                            tick,
    input  logic [NUM_EVENTS-1:0]           event_req,
    input  logic [NUM_EVENTS*DUR_W-1:0]     dur_table,
    output logic [3:0]                      sound_key,
    output logic                            playing,
    output logic                            request_time,
    output logic [DUR_W-1:0]                time_amount,
    output logic [$clog2(NUM_EVENTS)-1:0]   active_event
);

    localparam int IDX_W = $clog2(NUM_EVENTS);
    localparam int GAP_W = (GAP_TICKS < 2) ? 1 : $clog2(GAP_TICKS + 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_TICKS);

    typedef enum logic [1:0] {SIDLE, SPLAY, SGAP} state_t;

    state_t                 state, state_d;
    logic [DUR_W-1:0]       cnt, cnt_d;
    logic [GAP_W-1:0]       gap_cnt, gap_d;
    logic [IDX_W-1:0]       active_d;
    logic [NUM_EVENTS-1:0]  pending;
    logic [NUM_EVENTS-1:0]  arb_vec;
    logic                   any_req;
    logic                   start;
    logic [IDX_W-1:0]       win_idx;
    logic [DUR_W-1:0]       win_raw;
    logic [DUR_W-1:0]       win_dur;

    function automatic logic [IDX_W-1:0] top_index(input logic [NUM_EVENTS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_EVENTS; i++) begin
            if (v[i]) idx = IDX_W'(i);
        end
        return idx;
    endfunction

    // Remembered requests only compete while idle; in SPLAY only live requests can preempt.
    assign arb_vec = (state == SIDLE) ? (pending | event_req) : event_req;
    assign any_req = |arb_vec;
    assign win_idx = top_index(arb_vec);
    assign win_raw = dur_table[int'(win_idx)*DUR_W +: DUR_W];
    assign win_dur = (win_raw == '0) ? DUR_W'(1) : win_raw;

    // NOTE: every always_comb target gets a default first, so no path leaves a latch behind.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        gap_d    = gap_cnt;
        active_d = active_event;
        start    = 1'b0;
        case (state)
            SIDLE: begin
                if (any_req) start = 1'b1;
            end
            SPLAY: begin
                if (any_req && (win_idx > active_event)) begin
                    start = 1'b1;
                end else if (tick) begin
                    cnt_d = cnt - DUR_W'(1);
                    if (cnt == DUR_W'(1)) begin
                        active_d = '0;
                        if (GAP_TICKS > 0) begin
                            state_d = SGAP;
                            gap_d   = GAP_LOAD;
                        end else begin
                            state_d = SIDLE;
                        end
                    end
                end
            end
            SGAP: begin
                if (tick) begin
                    gap_d = gap_cnt - GAP_W'(1);
                    if (gap_cnt == GAP_W'(1)) state_d = SIDLE;
                end
            end
            default: state_d = SIDLE;
        endcase
        // A start (fresh or preempting) overrides any expiry decided above.
        if (start) begin
            state_d  = SPLAY;
            cnt_d    = win_dur;
            active_d = win_idx;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state        <= SIDLE;
            cnt          <= '0;
            gap_cnt      <= '0;
            active_event <= '0;
            request_time <= 1'b0;
            time_amount  <= '0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            gap_cnt      <= gap_d;
            active_event <= active_d;
            request_time <= start;
            time_amount  <= start ? win_dur : '0;
        end
    end

`ifdef AUDIO_PENDING_EN
    logic [NUM_EVENTS-1:0] pending_d;
    logic [NUM_EVENTS-1:0] start_mask;

    // Every request that does not start now is remembered; one bit per event, so repeats collapse.
    always_comb begin
        start_mask = '0;
        if (start) start_mask[win_idx] = 1'b1;
        pending_d = (pending | event_req) & ~start_mask;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) pending <= '0;
        else         pending <= pending_d;
    end
`else
    assign pending = '0;
`endif

    assign playing   = (state == SPLAY);
    assign sound_key = playing ? (4'(active_event) + 4'd1) : 4'(IDLE_KEY);

endmodule

// File: doc/audio_event_sequencer.md
AUDIO_EVENT_SEQUENCER -- requirements
Module: audio_event_sequencer

Interface
REQ-001 NUM_EVENTS, 4, number of sound-event request channels (2..8).
REQ-002 DUR_W, 4, width of per-event duration, in tick units.
REQ-003 GAP_TICKS, 1, silent ticks forced between two sounds (0 disables gap).
REQ-004 IDLE_KEY, 15, sound_key value driven when nothing plays.
REQ-005 clk  in  1  system clock.
REQ-006 resetN  in  1  reset, asynchronous, active-low.
REQ-007 tick  in  1  slow time-base pulse, one clk wide.
REQ-008 event_req  in  NUM_EVENTS  one-clk request pulses; bit i = event i.
REQ-009 dur_table  in  NUM_EVENTS*DUR_W  duration of event i in bits [i*DUR_W +: DUR_W].
REQ-010 sound_key  out  4  active sound code.
REQ-011 playing  out  1  high while a sound plays.
REQ-012 request_time  out  1  one-clk pulse when a sound starts.
REQ-013 time_amount  out  DUR_W  duration of the started sound; valid only with request_time, else 0.
REQ-014 active_event  out  $clog2(NUM_EVENTS)  index of the playing event, 0 when idle.

Function
REQ-015 FSM states SIDLE, SPLAY and SGAP; the FSM SHALL be a registered state with combinational next-state logic.
REQ-016 Priority: the highest set bit index in event_req (or pending, see REQ-028) SHALL win; lower bits in the same cycle SHALL be ignored.
REQ-017 SIDLE: on any winning request, go to SPLAY on the next clk and load the tick counter with dur_table[win].
REQ-018 Duration 0 SHALL be treated as 1.
REQ-019 request_time SHALL be high, and time_amount equal to the loaded duration, in the first SPLAY cycle only.
REQ-020 In SPLAY the counter SHALL decrement on each tick; a tick in the load cycle SHALL NOT count.
REQ-021 When the counter reaches 0, go to SGAP if GAP_TICKS>0, else SIDLE.
REQ-022 Preemption in SPLAY: a request with index strictly above active_event SHALL restart SPLAY with the new event and duration, and pulse request_time again; equal or lower requests SHALL be dropped.
REQ-023 If preemption and expiry coincide, preemption SHALL win.
REQ-024 SGAP SHALL count GAP_TICKS ticks and then return to SIDLE; requests in SGAP SHALL be dropped.
REQ-025 sound_key SHALL be active_event+1 in SPLAY and IDLE_KEY in SIDLE/SGAP; playing = (state==SPLAY).
REQ-026 All outputs SHALL be registered or derived from registered state only; event_req SHALL have no combinational path to outputs.

Reset
REQ-027 On resetN low, at any time including mid-sound: state SIDLE, counters 0, pending 0, sound_key=IDLE_KEY, playing=0, request_time=0, time_amount=0, active_event=0.

Configuration
REQ-028 AUDIO_PENDING_EN defined: dropped requests (REQ-022, REQ-024) SHALL set a pending bit per event; in SIDLE pending OR event_req SHALL be arbitrated; the winner's pending bit SHALL clear on start; repeated requests SHALL not stack.
REQ-029 AUDIO_PENDING_EN undefined: no pending storage; dropped requests are lost.

Verification
REQ-030 Defaults, dur_table event1=3; pulse event_req=4'b0010 in SIDLE -> next clk request_time=1, time_amount=3, sound_key=2; playing for 3 ticks; then 1 gap tick at IDLE_KEY; then SIDLE.
REQ-031 event_req=4'b0101 in SIDLE -> event 2 wins, sound_key=3; event 0 lost (macro off) or played after gap (macro on).
REQ-032 Event1 playing; pulse event 3 (dur 5) -> request_time again, time_amount=5, sound_key=4; pulse event 0 -> no change.
REQ-033 dur_table entry 0 -> plays exactly 1 tick; tick coincident with load cycle not counted.
REQ-034 Assert resetN low mid-SPLAY -> all outputs at reset values the same cycle; no request_time after release without a new request.
REQ-035 Macro on: event 1 requested twice during a sound of event 2 -> event 1 plays exactly once after the gap.
